operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Sequential successor to the combinational addressing-mode decoder. On a start pulse it decodes
//  the opcode (cc=op[1:0], bbb=op[4:2], aaa=op[7:5]) into a mode and an operand length. Immediate
//  lengths track the live A and X/Y register widths (8/16/32). It then reads the operand bytes over
//  the byte memory bus and returns an assembled little-endian operand. Sits between instruction
//  fetch and execute in the CPU core.
// PARAMETERS
//  ADDR_WIDTH      24  width of pc, next_pc, mem_address
//  TIMEOUT_CYCLES  16  max wait for mem_ready per byte (used only with OPERAND_FETCH_TIMEOUT_EN)
// PORTS
//  clk            in   1           system clock; one clock domain
//  reset          in   1           synchronous, active-high
//  start          in   1           begin decode/fetch; sampled only in IDLE
//  opcode         in   8           opcode byte
//  pc             in   ADDR_WIDTH  address of first operand byte
//  a_width        in   2           0=8,1=16,2=32-bit accumulator (3 treated as 2)
//  xy_width       in   2           same encoding, for index registers
//  busy           out  1           high in every state except IDLE
//  done           out  1           one-cycle pulse; outputs below valid and held until next start
//  mode           out  4           MODE_* encoding from addressing_mode.vinc
//  operand_bytes  out  3           operand bytes fetched, 0..4
//  operand        out  32          assembled operand, zero-extended
//  next_pc        out  ADDR_WIDTH  pc + operand_bytes, mod 2^ADDR_WIDTH
//  mem_address    out  ADDR_WIDTH  read address
//  mem_read       out  1           read strobe, asserted for exactly one cycle per byte
//  mem_data_in    in   8           read data, valid when mem_ready=1
//  mem_ready      in   1           read data valid; may arrive 1..N cycles after mem_read
//  fetch_error    out  1           only with OPERAND_FETCH_TIMEOUT_EN
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, mem_read, fetch_error=0; mode=MODE_NONE; operand,
//    operand_bytes, mem_address=0; next_pc=0. Reset mid-fetch drops mem_read in the same cycle.
//    Any late mem_ready after reset is ignored.
//  - States: IDLE -> DECODE -> (FETCH -> WAIT)*n -> DONE -> IDLE.
//    IDLE: start=1 latches opcode, pc and widths; clears operand to 0.
//    DECODE: computes mode/n from the table below. n=0 goes straight to DONE.
//    FETCH: mem_address = pc+i (wraps), mem_read=1 for one cycle, then WAIT.
//    WAIT: on mem_ready, operand[8i+7:8i] = mem_data_in; i++; if i==n go to DONE, else FETCH.
//    DONE: done=1 for one cycle, next_pc = pc+n, then IDLE.
//  - Latency: n=0 gives done 2 cycles after start. Each byte costs 1 cycle plus the memory wait.
//    With mem_ready arriving the cycle after mem_read, done comes 2+2n cycles after start.
//  - start while busy is ignored. mem_ready outside WAIT is ignored.
//  - Immediate length: Wa = 1/2/4 bytes for a_width 0/1/2; Wx likewise from xy_width.
//  - Decode table, cc:bbb -> mode, n:
//    cc=00: 000 IMM,Wx; 001 ZP,1; 010 NONE,0; 011 ABS,2; 100 NONE,1; 110 NONE,1;
//      101 -> ZP if aaa=0 else INDEXED_X, 1;
//      111 -> ABS if aaa in {0,4} else ABSOLUTE_X, 2
//    cc=01: 000 INDIRECT_X,1; 001 ZP,1; 010 IMM,Wa; 011 ABS,2; 100 INDIRECT_Y,1;
//      101 INDEXED_X,1; 110 ABSOLUTE_Y,2; 111 ABSOLUTE_X,2
//    cc=10: 000 IMM,Wx; 001 ZP,1; 010 MODE_A,0; 011 ABS,2; 101 INDEXED_X,1;
//      111 ABSOLUTE_Y,2; other NONE,0
//    cc=11: 000 STACK_RELATIVE,1; 001 INDIRECT_24,1; 011 ABS,3; 100 INDIRECT_S_Y,1;
//      101 INDIRECT_24_Y,2; 111 ABSOLUTE_X,3; other NONE,0
// CONFIGURATION
//  OPERAND_FETCH_TIMEOUT_EN defined:
//    - A wait counter runs in WAIT. If TIMEOUT_CYCLES elapse without mem_ready, go to DONE with
//      fetch_error=1 and operand_bytes = bytes actually received.
//    - fetch_error is cleared on the next start.
//  Not defined: WAIT holds indefinitely; fetch_error is absent from the port list.
// TESTING
//  - opcode 0xAD (LDA abs), pc=0x001000, bytes 34,12, ready after 1 cycle ->
//    mode=ABS, n=2, operand=0x00001234, next_pc=0x001002, done at cycle 6.
//  - opcode 0xA9, a_width=2, bytes 78,56,34,12 -> IMM, n=4, operand=0x12345678;
//    same opcode with a_width=0 -> n=1.
//  - opcode 0x0A (ASL A) -> MODE_A, n=0, no mem_read, done 2 cycles after start.
//  - opcode 0xAF (cc=11,bbb=011), pc=0xFFFFFE -> reads at FFFFFE, FFFFFF, 000000; next_pc=0x000001.
//  - start repeated mid-fetch is ignored; reset asserted in WAIT -> IDLE next cycle, mem_read=0.
//  - With OPERAND_FETCH_TIMEOUT_EN: mem_ready withheld on byte 2 of 0xAD ->
//    fetch_error=1, operand_bytes=1 after 16 cycles.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: decodes an opcode's addressing mode and operand length, then
// reads the operand bytes over a byte-wide memory bus and returns them
// assembled little-endian.
// Optional feature macro: OPERAND_FETCH_TIMEOUT_EN. When defined, each byte
// wait is bounded by TIMEOUT_CYCLES and a fetch_error output is added.
module operand_fetch #(
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            a_width,
    input  logic [1:0]            xy_width,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            mode,
    output logic [2:0]            operand_bytes,
    output logic [31:0]           operand,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [7:0]            mem_data_in,
    input  logic                  mem_ready
`ifdef OPERAND_FETCH_TIMEOUT_EN
    ,output logic                 fetch_error
`endif
);

    localparam logic [3:0] M_NONE  = 4'd0,  M_IMM  = 4'd1,  M_ZP   = 4'd2,  M_ABS  = 4'd3;
    localparam logic [3:0] M_IDXX  = 4'd4,  M_ABSX = 4'd5,  M_ABSY = 4'd6,  M_INDX = 4'd7;
    localparam logic [3:0] M_INDY  = 4'd8,  M_A    = 4'd9,  M_SR   = 4'd10, M_I24  = 4'd11;
    localparam logic [3:0] M_ISY   = 4'd12, M_I24Y = 4'd13;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_FETCH, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            op_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [1:0]            aw_q, xw_q;
    logic [2:0]            n_q, idx, idx_inc;
    logic [3:0]            dec_mode;
    logic [2:0]            dec_n;
    logic                  last_byte, timeout_hit;

    // Immediate length follows the live register width; encoding 3 acts as 32-bit.
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign idx_inc     = idx + 3'd1;
    assign last_byte   = (idx_inc == n_q);
    assign mem_address = pc_q + ADDR_WIDTH'(idx);

`ifdef OPERAND_FETCH_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WCW-1:0] wait_cnt;
    assign timeout_hit = (state_q == S_WAIT) && !mem_ready
                         && (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Addressing-mode decode of the latched opcode, keyed on cc:bbb.
    always_comb begin
        dec_mode = M_NONE;
        dec_n    = 3'd0;
        case ({op_q[1:0], op_q[4:2]})
            5'b00_000: begin dec_mode = M_IMM;  dec_n = width_bytes(xw_q); end
            5'b00_001: begin dec_mode = M_ZP;   dec_n = 3'd1; end
            5'b00_011: begin dec_mode = M_ABS;  dec_n = 3'd2; end
            5'b00_100,
            5'b00_110: begin dec_mode = M_NONE; dec_n = 3'd1; end
            5'b00_101: begin
                dec_mode = (op_q[7:5] == 3'd0) ? M_ZP : M_IDXX;
                dec_n    = 3'd1;
            end
            5'b00_111: begin
                dec_mode = (op_q[7:5] == 3'd0 || op_q[7:5] == 3'd4) ? M_ABS : M_ABSX;
                dec_n    = 3'd2;
            end
            5'b01_000: begin dec_mode = M_INDX; dec_n = 3'd1; end
            5'b01_001: begin dec_mode = M_ZP;   dec_n = 3'd1; end
            5'b01_010: begin dec_mode = M_IMM;  dec_n = width_bytes(aw_q); end
            5'b01_011: begin dec_mode = M_ABS;  dec_n = 3'd2; end
            5'b01_100: begin dec_mode = M_INDY; dec_n = 3'd1; end
            5'b01_101: begin dec_mode = M_IDXX; dec_n = 3'd1; end
            5'b01_110: begin dec_mode = M_ABSY; dec_n = 3'd2; end
            5'b01_111: begin dec_mode = M_ABSX; dec_n = 3'd2; end
            5'b10_000: begin dec_mode = M_IMM;  dec_n = width_bytes(xw_q); end
            5'b10_001: begin dec_mode = M_ZP;   dec_n = 3'd1; end
            5'b10_010: begin dec_mode = M_A;    dec_n = 3'd0; end
            5'b10_011: begin dec_mode = M_ABS;  dec_n = 3'd2; end
            5'b10_101: begin dec_mode = M_IDXX; dec_n = 3'd1; end
            5'b10_111: begin dec_mode = M_ABSY; dec_n = 3'd2; end
            5'b11_000: begin dec_mode = M_SR;   dec_n = 3'd1; end
            5'b11_001: begin dec_mode = M_I24;  dec_n = 3'd1; end
            5'b11_011: begin dec_mode = M_ABS;  dec_n = 3'd3; end
            5'b11_100: begin dec_mode = M_ISY;  dec_n = 3'd1; end
            5'b11_101: begin dec_mode = M_I24Y; dec_n = 3'd2; end
            5'b11_111: begin dec_mode = M_ABSX; dec_n = 3'd3; end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and control strobes; reset kills an in-flight read strobe at once.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        mem_read = (state_q == S_FETCH) && !reset;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DECODE;
            S_DECODE: state_d = (dec_n == 3'd0) ? S_DONE : S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT: begin
                if (mem_ready)        state_d = last_byte ? S_DONE : S_FETCH;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request latch, byte assembly and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= '0;
            pc_q          <= '0;
            aw_q          <= '0;
            xw_q          <= '0;
            n_q           <= '0;
            idx           <= '0;
            mode          <= M_NONE;
            operand       <= '0;
            operand_bytes <= '0;
            next_pc       <= '0;
`ifdef OPERAND_FETCH_TIMEOUT_EN
            wait_cnt      <= '0;
            fetch_error   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    op_q    <= opcode;
                    pc_q    <= pc;
                    aw_q    <= a_width;
                    xw_q    <= xy_width;
                    idx     <= '0;
                    operand <= '0;
`ifdef OPERAND_FETCH_TIMEOUT_EN
                    fetch_error <= 1'b0;
`endif
                end
                S_DECODE: begin
                    mode <= dec_mode;
                    n_q  <= dec_n;
                    if (dec_n == 3'd0) begin
                        operand_bytes <= '0;
                        next_pc       <= pc_q;
                    end
                end
`ifdef OPERAND_FETCH_TIMEOUT_EN
                S_FETCH: wait_cnt <= '0;
`endif
                S_WAIT: begin
                    if (mem_ready) begin
                        operand[{idx[1:0], 3'b000} +: 8] <= mem_data_in;
                        idx <= idx_inc;
                        if (last_byte) begin
                            operand_bytes <= idx_inc;
                            next_pc       <= pc_q + ADDR_WIDTH'(idx_inc);
                        end
                    end
`ifdef OPERAND_FETCH_TIMEOUT_EN
                    else if (timeout_hit) begin
                        fetch_error   <= 1'b1;
                        operand_bytes <= idx;
                        next_pc       <= pc_q + ADDR_WIDTH'(idx);
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written reset/restart
// sequences, and random opcodes checked against a table-based decode model.
module tb_operand_fetch;

    localparam int TMO = 16;
    localparam int M_NONE = 0, M_IMM = 1, M_ZP = 2, M_ABS = 3, M_IDXX = 4, M_ABSX = 5;
    localparam int M_ABSY = 6, M_INDX = 7, M_INDY = 8, M_A = 9, M_SR = 10, M_I24 = 11;
    localparam int M_ISY = 12, M_I24Y = 13;

    logic        clk, reset, start, busy, done, mem_read, mem_ready;
    logic [7:0]  opcode, mem_data_in;
    logic [23:0] pc, next_pc, mem_address;
    logic [1:0]  a_width, xy_width;
    logic [3:0]  mode;
    logic [2:0]  operand_bytes;
    logic [31:0] operand;
`ifdef OPERAND_FETCH_TIMEOUT_EN
    logic        fetch_error;
`endif

    int n_pass = 0, n_total = 0;

    operand_fetch #(.ADDR_WIDTH(24), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc(pc),
        .a_width(a_width), .xy_width(xy_width), .busy(busy), .done(done),
        .mode(mode), .operand_bytes(operand_bytes), .operand(operand),
        .next_pc(next_pc), .mem_address(mem_address), .mem_read(mem_read),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready)
`ifdef OPERAND_FETCH_TIMEOUT_EN
        , .fetch_error(fetch_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Decode model: per-cc lookup tables, -1 = index width, -2 = accumulator width.
    function automatic void ref_decode(input logic [7:0] op, input logic [1:0] aw,
                                       input logic [1:0] xw, output logic [3:0] m, output int n);
        int mt[4][8];
        int nt[4][8];
        int cc, bbb, aaa, wa, wx;
        mt = '{'{M_IMM, M_ZP, M_NONE, M_ABS, M_NONE, M_ZP, M_NONE, M_ABS},
               '{M_INDX, M_ZP, M_IMM, M_ABS, M_INDY, M_IDXX, M_ABSY, M_ABSX},
               '{M_IMM, M_ZP, M_A, M_ABS, M_NONE, M_IDXX, M_NONE, M_ABSY},
               '{M_SR, M_I24, M_NONE, M_ABS, M_ISY, M_I24Y, M_NONE, M_ABSX}};
        nt = '{'{-1, 1, 0, 2, 1, 1, 1, 2},
               '{1, 1, -2, 2, 1, 1, 2, 2},
               '{-1, 1, 0, 2, 0, 1, 0, 2},
               '{1, 1, 0, 3, 1, 2, 0, 3}};
        cc  = int'(op[1:0]);
        bbb = int'(op[4:2]);
        aaa = int'(op[7:5]);
        wa  = 1 << ((aw > 2) ? 2 : int'(aw));
        wx  = 1 << ((xw > 2) ? 2 : int'(xw));
        m = 4'(mt[cc][bbb]);
        n = nt[cc][bbb];
        if (n == -1) n = wx;
        if (n == -2) n = wa;
        if (cc == 0 && bbb == 5 && aaa != 0) m = 4'(M_IDXX);
        if (cc == 0 && bbb == 7 && !(aaa == 0 || aaa == 4)) m = 4'(M_ABSX);
    endfunction

    // One full start..done transaction with a latency-configurable memory responder.
    // stop_after limits how many bytes memory ever answers (later reads are withheld).
    task automatic run_txn(input string nm, input logic [7:0] op, input logic [23:0] p,
                           input logic [1:0] aw, input logic [1:0] xw, input int lat,
                           input logic [31:0] data, input int stop_after, input bit noise,
                           input bit restart, input logic [3:0] exp_mode, input int exp_n);
        int cyc, served, reads, ready_at, done_cyc, k, exp_lat;
        bit pending, outstanding, addr_ok, exp_err;
        logic [31:0] exp_op;
        logic [23:0] exp_pc;
        exp_err = (stop_after < exp_n);
        k       = exp_err ? stop_after : exp_n;
        exp_op  = '0;
        for (int i = 0; i < k; i++) exp_op[8*i +: 8] = data[8*i +: 8];
        exp_pc  = p + 24'(k);
        exp_lat = exp_err ? 2 + k * (1 + lat) + 1 + TMO : 2 + exp_n * (1 + lat);
        served = 0; reads = 0; ready_at = 0; done_cyc = -1;
        pending = 0; outstanding = 0; addr_ok = 1;
        opcode = op; pc = p; a_width = aw; xy_width = xw;
        start = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < 200) begin
            if (restart && cyc == 3) begin start = 1'b1; opcode = 8'h0A; end
            else start = 1'b0;
            mem_ready = 1'b0;
            if (mem_read) begin
                if (mem_address !== p + 24'(reads)) addr_ok = 0;
                reads++;
                outstanding = 1;
                if (served < stop_after) begin pending = 1; ready_at = cyc + lat; end
            end
            if (pending && cyc == ready_at) begin
                mem_ready = 1'b1; mem_data_in = data[8*served +: 8];
                served++; pending = 0; outstanding = 0;
            end else if (noise && !outstanding && $urandom_range(0, 1) == 1) begin
                mem_ready = 1'b1; mem_data_in = 8'($urandom);
            end
            if (done) begin done_cyc = cyc; break; end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({nm, " done latency"}, 64'(done_cyc), 64'(exp_lat));
        chk({nm, " mode"}, 64'(mode), 64'(exp_mode));
        chk({nm, " operand_bytes"}, 64'(operand_bytes), 64'(k));
        chk({nm, " operand"}, 64'(operand), 64'(exp_op));
        chk({nm, " next_pc"}, 64'(next_pc), 64'(exp_pc));
        chk({nm, " read count"}, 64'(reads), 64'(exp_err ? k + 1 : exp_n));
        chk({nm, " read addresses"}, 64'(addr_ok), 64'd1);
        chk({nm, " busy in done"}, 64'(busy), 64'd1);
`ifdef OPERAND_FETCH_TIMEOUT_EN
        chk({nm, " fetch_error"}, 64'(fetch_error), 64'(exp_err));
`endif
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk({nm, " done pulse width"}, 64'(done), 64'd0);
        chk({nm, " idle after done"}, 64'(busy), 64'd0);
        chk({nm, " operand held"}, 64'(operand), 64'(exp_op));
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] pc;
        logic [1:0]  aw, xw;
        int          lat;
        logic [31:0] data;
        int          mode;
        int          n;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    logic [7:0]  r_op;
    logic [23:0] r_pc;
    logic [1:0]  r_aw, r_xw;
    logic [3:0]  r_mode;
    int          r_n;

    initial begin
        vt[0]  = '{8'hAD, 24'h001000, 2'd0, 2'd0, 1, 32'hA5A51234, M_ABS, 2};
        vt[1]  = '{8'hA9, 24'h000200, 2'd2, 2'd0, 1, 32'h12345678, M_IMM, 4};
        vt[2]  = '{8'hA9, 24'h000200, 2'd0, 2'd0, 1, 32'h12345678, M_IMM, 1};
        vt[3]  = '{8'hA9, 24'h000300, 2'd1, 2'd2, 2, 32'hCAFEBABE, M_IMM, 2};
        vt[4]  = '{8'h0A, 24'h000400, 2'd0, 2'd0, 1, 32'hFFFFFFFF, M_A, 0};
        vt[5]  = '{8'hAF, 24'hFFFFFE, 2'd0, 2'd0, 1, 32'h99563412, M_ABS, 3};
        vt[6]  = '{8'hA2, 24'h000500, 2'd0, 2'd1, 1, 32'h1111BEEF, M_IMM, 2};
        vt[7]  = '{8'h00, 24'h000600, 2'd2, 2'd3, 1, 32'hDEADBEEF, M_IMM, 4};
        vt[8]  = '{8'h3C, 24'h000700, 2'd0, 2'd0, 1, 32'h44332211, M_ABSX, 2};
        vt[9]  = '{8'h9C, 24'h000800, 2'd0, 2'd0, 3, 32'h44332211, M_ABS, 2};
        vt[10] = '{8'h34, 24'h000900, 2'd0, 2'd0, 1, 32'h000000F0, M_IDXX, 1};
        vt[11] = '{8'h14, 24'h000A00, 2'd0, 2'd0, 1, 32'h0000000F, M_ZP, 1};
        vt[12] = '{8'h10, 24'h000B00, 2'd0, 2'd0, 2, 32'h00000080, M_NONE, 1};
        vt[13] = '{8'h08, 24'h000C00, 2'd2, 2'd2, 1, 32'h12345678, M_NONE, 0};
        vt[14] = '{8'h17, 24'h000D00, 2'd0, 2'd0, 1, 32'h0000ABCD, M_I24Y, 2};
        vt[15] = '{8'h1F, 24'hFFFFFF, 2'd0, 2'd0, 1, 32'h00C0FFEE, M_ABSX, 3};
        vt[16] = '{8'hB6, 24'h000E00, 2'd0, 2'd0, 1, 32'h00000042, M_IDXX, 1};
        vt[17] = '{8'h13, 24'h000F00, 2'd0, 2'd0, 1, 32'h00000077, M_ISY, 1};

        reset = 1'b1; start = 1'b0; opcode = '0; pc = '0; a_width = '0; xy_width = '0;
        mem_ready = 1'b0; mem_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset mem_read", 64'(mem_read), 64'd0);
        chk("reset mode", 64'(mode), 64'(M_NONE));
        chk("reset operand", 64'(operand), 64'd0);
        chk("reset operand_bytes", 64'(operand_bytes), 64'd0);
        chk("reset mem_address", 64'(mem_address), 64'd0);
        chk("reset next_pc", 64'(next_pc), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            run_txn($sformatf("vec%0d", i), vt[i].op, vt[i].pc, vt[i].aw, vt[i].xw, vt[i].lat,
                    vt[i].data, 4, 0, 0, 4'(vt[i].mode), vt[i].n);

        // start pulsed again while fetching must not disturb the transaction
        run_txn("restart", 8'hAD, 24'h003000, 2'd0, 2'd0, 1, 32'h00005566, 4, 0, 1, 4'(M_ABS), 2);

        // reset during FETCH: strobe drops in the same cycle, idle afterwards
        opcode = 8'hAD; pc = 24'h123456; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("fetch strobe before reset", 64'(mem_read), 64'd1);
        reset = 1'b1; #1;
        chk("reset drops mem_read", 64'(mem_read), 64'd0);
        @(posedge clk); #1; reset = 1'b0;
        chk("reset mid-fetch busy", 64'(busy), 64'd0);
        chk("reset mid-fetch mode", 64'(mode), 64'(M_NONE));
        chk("reset mid-fetch operand", 64'(operand), 64'd0);
        chk("reset mid-fetch next_pc", 64'(next_pc), 64'd0);
        mem_ready = 1'b1; mem_data_in = 8'hEE;
        @(posedge clk); #1; mem_ready = 1'b0;
        chk("late ready busy", 64'(busy), 64'd0);
        chk("late ready operand", 64'(operand), 64'd0);

        // reset during WAIT
        opcode = 8'hAD; pc = 24'h000010; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in wait busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("reset in wait busy", 64'(busy), 64'd0);
        chk("reset in wait mem_read", 64'(mem_read), 64'd0);

`ifdef OPERAND_FETCH_TIMEOUT_EN
        run_txn("timeout", 8'hAD, 24'h002000, 2'd0, 2'd0, 1, 32'h000000C3, 1, 0, 0, 4'(M_ABS), 2);
`endif

        for (int r = 0; r < 60; r++) begin
            r_op = 8'($urandom);
            r_pc = 24'($urandom);
            r_aw = 2'($urandom);
            r_xw = 2'($urandom);
            ref_decode(r_op, r_aw, r_xw, r_mode, r_n);
            run_txn($sformatf("rnd%0d op%02h", r, r_op), r_op, r_pc, r_aw, r_xw,
                    int'($urandom_range(1, 3)), $urandom, 4, 1, 0, r_mode, r_n);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
